// File: rtl/pacman_pkg.sv
// Shared game-map definitions: tile codes, map size defaults, scheduler states
// and the {y,x} tile-address packing used by the map RAM.
package pacman_pkg;

   localparam logic [3:0] TILE_EMPTY  = 4'd0;
   localparam logic [3:0] TILE_WALL   = 4'd1;
   localparam logic [3:0] TILE_PILL   = 4'd2;
   localparam logic [3:0] TILE_PACMAN = 4'd3;
   localparam logic [3:0] TILE_GHOST  = 4'd4;

   localparam int MAP_W_DEF = 40;
   localparam int MAP_H_DEF = 30;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_OLD = 2'd1,
      WR_NEW = 2'd2,
      ACK    = 2'd3
   } sched_state_t;

   function automatic logic [10:0] pack_addr(input logic [4:0] y, input logic [5:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/map_write_sched_if.sv
// Mover-to-scheduler request bus plus the map RAM write port; the scheduler
// uses the slave modport, movers/RAM side the master modport.
interface map_write_sched_if #(
   parameter int NREQ = 5
);
   logic [NREQ-1:0]   req;
   logic [NREQ*6-1:0] old_x;
   logic [NREQ*5-1:0] old_y;
   logic [NREQ*6-1:0] new_x;
   logic [NREQ*5-1:0] new_y;
   logic [NREQ*4-1:0] old_tile;
   logic [NREQ*4-1:0] new_tile;
   logic [NREQ-1:0]   done;
   logic              drop;
   logic              busy;
   logic              ram_wren;
   logic [10:0]       ram_addr;
   logic [3:0]        ram_wdata;

   modport master (
      output req, old_x, old_y, new_x, new_y, old_tile, new_tile,
      input  done, drop, busy, ram_wren, ram_addr, ram_wdata
   );

   modport slave (
      input  req, old_x, old_y, new_x, new_y, old_tile, new_tile,
      output done, drop, busy, ram_wren, ram_addr, ram_wdata
   );
endinterface

// File: rtl/map_write_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first unmasked request at or after ptr
// wins; one-hot grant, vld when any request is eligible.
module rr_arbiter #(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          vld
);
   logic [IW-1:0] idx;

   always_comb begin
      gnt = '0;
      vld = 1'b0;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         idx = IW'((int'(ptr) + i) % N);
         if (!vld && req[idx] && !mask[idx]) begin
            gnt[idx] = 1'b1;
            vld      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/map_write_sched.sv
// Owns the map RAM write port: grants one mover at a time, erases/restores the
// old tile then writes the new one, then pulses done. Optional: SCHED_VBLANK_GATE_EN.
module map_write_sched
   import pacman_pkg::*;
#(
   parameter int NREQ  = 5,
   parameter int MAP_W = MAP_W_DEF,
   parameter int MAP_H = MAP_H_DEF
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             vblank,
   map_write_sched_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   sched_state_t state, state_nxt;

   logic [IW-1:0] ptr, g_r, gnt_idx;
   logic          mask_vld;
   logic [NREQ-1:0] mask, gnt;
   logic          arb_vld, gate, take;

   logic [5:0] old_x_r, new_x_r;
   logic [4:0] old_y_r, new_y_r;
   logic [3:0] old_tile_r, new_tile_r;
   logic       same_r, old_bad_r, new_bad_r;

   logic [5:0] sel_old_x, sel_new_x;
   logic [4:0] sel_old_y, sel_new_y;

`ifdef SCHED_VBLANK_GATE_EN
   assign gate = vblank;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign gate = 1'b1;
`endif

   // The just-served mover sits out one IDLE cycle so it can retire its req.
   always_comb begin
      mask = '0;
      if (mask_vld) mask[g_r] = 1'b1;
   end

   rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
      .req  (bus.req),
      .mask (mask),
      .ptr  (ptr),
      .gnt  (gnt),
      .vld  (arb_vld)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) gnt_idx = IW'(i);
   end

   assign sel_old_x = bus.old_x[int'(gnt_idx)*6 +: 6];
   assign sel_old_y = bus.old_y[int'(gnt_idx)*5 +: 5];
   assign sel_new_x = bus.new_x[int'(gnt_idx)*6 +: 6];
   assign sel_new_y = bus.new_y[int'(gnt_idx)*5 +: 5];

   assign take = (state == IDLE) && arb_vld && gate;

   always_ff @(posedge CLOCK_50) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         ptr        <= '0;
         g_r        <= '0;
         mask_vld   <= 1'b0;
         old_x_r    <= '0;
         old_y_r    <= '0;
         new_x_r    <= '0;
         new_y_r    <= '0;
         old_tile_r <= '0;
         new_tile_r <= '0;
         same_r     <= 1'b0;
         old_bad_r  <= 1'b0;
         new_bad_r  <= 1'b0;
      end else begin
         mask_vld <= (state == ACK);
         if (state == ACK)
            ptr <= (int'(g_r) == NREQ - 1) ? '0 : g_r + 1'b1;
         // Operands are frozen here; the mover may change its inputs mid-service.
         if (take) begin
            g_r        <= gnt_idx;
            old_x_r    <= sel_old_x;
            old_y_r    <= sel_old_y;
            new_x_r    <= sel_new_x;
            new_y_r    <= sel_new_y;
            old_tile_r <= bus.old_tile[int'(gnt_idx)*4 +: 4];
            new_tile_r <= bus.new_tile[int'(gnt_idx)*4 +: 4];
            same_r     <= (sel_old_x == sel_new_x) && (sel_old_y == sel_new_y);
            old_bad_r  <= (int'(sel_old_x) >= MAP_W) || (int'(sel_old_y) >= MAP_H);
            new_bad_r  <= (int'(sel_new_x) >= MAP_W) || (int'(sel_new_y) >= MAP_H);
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.ram_wren  = 1'b0;
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      bus.done      = '0;
      bus.drop      = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            if (take) state_nxt = WR_OLD;
         end
         WR_OLD: begin
            bus.busy = 1'b1;
            if (!same_r && !old_bad_r) begin
               bus.ram_wren  = 1'b1;
               bus.ram_addr  = pack_addr(old_y_r, old_x_r);
               bus.ram_wdata = old_tile_r;
            end
            state_nxt = WR_NEW;
         end
         WR_NEW: begin
            bus.busy = 1'b1;
            if (!new_bad_r) begin
               bus.ram_wren  = 1'b1;
               bus.ram_addr  = pack_addr(new_y_r, new_x_r);
               bus.ram_wdata = new_tile_r;
            end
            state_nxt = ACK;
         end
         ACK: begin
            bus.busy     = 1'b1;
            bus.done[g_r] = 1'b1;
            bus.drop     = old_bad_r || new_bad_r;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_map_write_sched.sv
// Directed bench for map_write_sched: single move, contention, wall collision,
// out-of-range drop, reset mid-service, and vblank gating when enabled.
module tb_map_write_sched;
   localparam int NREQ = 5;

   logic CLOCK_50 = 1'b0;
   logic reset;
   logic vblank;
   int   errors = 0;
   int   checks = 0;

   map_write_sched_if #(.NREQ(NREQ)) bus ();

   map_write_sched #(.NREQ(NREQ), .MAP_W(40), .MAP_H(30)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .vblank   (vblank),
      .bus      (bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   function automatic int addr(input int x, input int y);
      return y * 64 + x;
   endfunction

   task automatic set_mover(input int i, input int ox, input int oy,
                            input int nx, input int ny, input int ot, input int nt);
      bus.old_x[i*6 +: 6]    = 6'(ox);
      bus.old_y[i*5 +: 5]    = 5'(oy);
      bus.new_x[i*6 +: 6]    = 6'(nx);
      bus.new_y[i*5 +: 5]    = 5'(ny);
      bus.old_tile[i*4 +: 4] = 4'(ot);
      bus.new_tile[i*4 +: 4] = 4'(nt);
   endtask

   task automatic check_write(input string tag, input int wren, input int a, input int d);
      check({tag, "_wren"}, int'(bus.ram_wren), wren);
      check({tag, "_addr"}, int'(bus.ram_addr), a);
      check({tag, "_wdata"}, int'(bus.ram_wdata), d);
   endtask

   int order [3] = '{0, 2, 4};

   initial begin
      reset        = 1'b1;
`ifdef SCHED_VBLANK_GATE_EN
      vblank       = 1'b1;
`else
      vblank       = 1'b0;
`endif
      bus.req      = '0;
      bus.old_x    = '0;
      bus.old_y    = '0;
      bus.new_x    = '0;
      bus.new_y    = '0;
      bus.old_tile = '0;
      bus.new_tile = '0;
      step();
      step();
      reset = 1'b0;

      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_drop", int'(bus.drop), 0);
      check_write("rst", 0, 0, 0);

      // Single move for Pac-Man, req held one cycle past done to exercise the mask.
      set_mover(0, 20, 20, 20, 19, 0, 3);
      bus.req[0] = 1'b1;
      step();
      check_write("t1_old", 1, addr(20, 20), 0);
      check("t1_busy_old", int'(bus.busy), 1);
      step();
      check_write("t1_new", 1, addr(20, 19), 3);
      check("t1_busy_new", int'(bus.busy), 1);
      step();
      check("t1_done", int'(bus.done), 1);
      check("t1_drop", int'(bus.drop), 0);
      check("t1_ack_wren", int'(bus.ram_wren), 0);
      check("t1_busy_ack", int'(bus.busy), 1);
      step();
      check("t1_idle_busy", int'(bus.busy), 0);
      check("t1_idle_done", int'(bus.done), 0);
      step();
      check("t1_mask_busy", int'(bus.busy), 0);
      bus.req[0] = 1'b0;
      step();
      check("t1_quiet_busy", int'(bus.busy), 0);

      // Contention from ptr 0: movers 0, 2, 4 served in order, 4 cycles apart.
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < NREQ; i++) set_mover(i, i, i + 1, i + 10, i + 1, 2, 4);
      bus.req = 5'b10101;
      for (int k = 0; k < 3; k++) begin
         step();
         check_write($sformatf("t2_old%0d", order[k]), 1, addr(order[k], order[k] + 1), 2);
         step();
         check_write($sformatf("t2_new%0d", order[k]), 1, addr(order[k] + 10, order[k] + 1), 4);
         step();
         check($sformatf("t2_done%0d", order[k]), int'(bus.done), 1 << order[k]);
         check($sformatf("t2_ackwr%0d", order[k]), int'(bus.ram_wren), 0);
         bus.req[order[k]] = 1'b0;
         step();
         check($sformatf("t2_idle%0d", order[k]), int'(bus.busy), 0);
         check($sformatf("t2_idlewr%0d", order[k]), int'(bus.ram_wren), 0);
      end

      // Wall collision: old == new, first write skipped.
      set_mover(1, 5, 7, 5, 7, 4, 4);
      bus.req[1] = 1'b1;
      step();
      check_write("t3_old", 0, 0, 0);
      check("t3_busy", int'(bus.busy), 1);
      step();
      check_write("t3_new", 1, addr(5, 7), 4);
      step();
      check("t3_done", int'(bus.done), 2);
      check("t3_drop", int'(bus.drop), 0);
      bus.req[1] = 1'b0;
      step();

      // Out of range new_x: second write suppressed, drop with done.
      set_mover(3, 10, 3, 45, 3, 0, 3);
      bus.req[3] = 1'b1;
      step();
      check_write("t4_old", 1, addr(10, 3), 0);
      step();
      check_write("t4_new", 0, 0, 0);
      step();
      check("t4_done", int'(bus.done), 8);
      check("t4_drop", int'(bus.drop), 1);
      bus.req[3] = 1'b0;
      step();

      // Reset during WR_NEW: abort, ptr back to 0.
      set_mover(2, 1, 1, 2, 1, 2, 4);
      bus.req[2] = 1'b1;
      step();
      check_write("t5_old", 1, addr(1, 1), 2);
      step();
      check_write("t5_new", 1, addr(2, 1), 4);
      reset = 1'b1;
      step();
      check("t5_rst_wren", int'(bus.ram_wren), 0);
      check("t5_rst_busy", int'(bus.busy), 0);
      check("t5_rst_done", int'(bus.done), 0);
      reset = 1'b0;
      bus.req[2] = 1'b0;
      step();
      check("t5_post_done", int'(bus.done), 0);
      // With ptr 0 mover 1 wins over 4; a stale ptr (4) would pick 4 first.
      set_mover(1, 8, 9, 9, 9, 0, 4);
      set_mover(4, 30, 2, 31, 2, 1, 4);
      bus.req = 5'b10010;
      step();
      check_write("t5_m1_old", 1, addr(8, 9), 0);
      step();
      step();
      check("t5_m1_done", int'(bus.done), 2);
      bus.req[1] = 1'b0;
      step();
      step();
      check_write("t5_m4_old", 1, addr(30, 2), 1);
      step();
      check_write("t5_m4_new", 1, addr(31, 2), 4);
      step();
      check("t5_m4_done", int'(bus.done), 16);
      bus.req[4] = 1'b0;
      step();

`ifdef SCHED_VBLANK_GATE_EN
      // Gate: no grant until vblank, then a started service finishes regardless.
      vblank = 1'b0;
      set_mover(3, 4, 4, 5, 4, 0, 3);
      bus.req[3] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("t6_gate_wren%0d", k), int'(bus.ram_wren), 0);
         check($sformatf("t6_gate_busy%0d", k), int'(bus.busy), 0);
      end
      vblank = 1'b1;
      step();
      check_write("t6_old", 1, addr(4, 4), 0);
      vblank = 1'b0;
      step();
      check_write("t6_new", 1, addr(5, 4), 3);
      step();
      check("t6_done", int'(bus.done), 8);
      bus.req[3] = 1'b0;
      step();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/map_write_sched.md
# map_write_sched

Scheduler that owns the single write port of the game-map tile RAM and shares it among movers (Pac-Man plus ghosts). Each mover's location controller posts a move request (old tile position + restore code, new tile position + sprite code). The scheduler grants one request at a time and sequences exactly two RAM writes: erase/restore the old position, then write the new one. It then returns a one-cycle `done` to that mover, which is the `done` its location controller uses to commit curr <= next.

## Interface
Parameters:
- NREQ, 5, number of requesters; index 0 = Pac-Man, 1..NREQ-1 = ghosts
- MAP_W, 40, map width in tiles; legal x is 0..MAP_W-1
- MAP_H, 30, map height in tiles; legal y is 0..MAP_H-1

Ports (clock and reset first):
- CLOCK_50  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- vblank  in  1  frame blanking window from the VGA timing block; used only with the gate macro
- req  in  NREQ  level move request per mover; held until its done
- old_x  in  NREQ*6  current x per mover, packed, requester i at [6i+5:6i]
- old_y  in  NREQ*5  current y per mover, packed
- new_x  in  NREQ*6  next x per mover, packed
- new_y  in  NREQ*5  next y per mover, packed
- old_tile  in  NREQ*4  tile code written at the old position (EMPTY for Pac-Man; the underlying tile for ghosts)
- new_tile  in  NREQ*4  tile code written at the new position
- done  out  NREQ  one-hot, one-cycle pulse to the served requester
- drop  out  1  pulses with done when at least one of the two writes was suppressed as out of range
- busy  out  1  high in any non-IDLE state
- ram_wren  out  1  RAM write enable
- ram_addr  out  11  tile address {y[4:0], x[5:0]}
- ram_wdata  out  4  tile code

## Operation
- States: IDLE, WR_OLD, WR_NEW, ACK.
- IDLE:
  - If any eligible req is high, pick a winner g by round-robin, starting the search at ptr.
  - On that edge, latch g and all of g's operands into internal registers, then go to WR_OLD.
  - Inputs are not re-sampled after the latch.
- WR_OLD: ram_wren=1, ram_addr={old_y,old_x}, ram_wdata=old_tile; then go to WR_NEW.
- WR_NEW: ram_wren=1, ram_addr={new_y,new_x}, ram_wdata=new_tile; then go to ACK.
- ACK: done[g]=1 and ptr <= (g+1) mod NREQ; then go to IDLE.
- Same position (old == new, e.g. wall collision): WR_OLD is skipped (wren=0 that cycle) and the new tile is still written. Timing is unchanged.
- Range check: x >= MAP_W or y >= MAP_H suppresses that write (wren=0) and sets drop in ACK. The sequence still completes and done still pulses.
- Eligibility: after ACK, requester g is masked for the single following IDLE cycle. This lets a registered requester drop req after seeing done.
- ram_* and done/drop/busy are decoded from the state and latched registers only, with no combinational path from req.
- ram_wren, done, drop and busy are 0 in IDLE. ram_addr and ram_wdata are 0 whenever wren=0.

## Timing
- Reset values: state IDLE, ptr 0, all outputs 0.
- Latency: req high at edge t (IDLE), so WR_OLD runs in cycle t+1, WR_NEW in t+2, ACK/done in t+3.
- Back-to-back service: the next grant can be latched at the edge that ends the first IDLE after ACK, giving 4 cycles per move minimum.
- Simultaneous requests: served in round-robin order from ptr. No requester waits more than NREQ grants.
- req dropped mid-service: ignored; the service completes and done still pulses.
- Reset mid-operation: immediate return to IDLE. No further writes and no done. Requesters must re-request.

## Configuration
- SCHED_VBLANK_GATE_EN defined: a grant is latched in IDLE only while vblank=1. A service already started always completes even if vblank falls.
- SCHED_VBLANK_GATE_EN undefined: vblank is ignored and grants are latched whenever an eligible req is present.

## Structure
- pacman_pkg holds:
  - tile codes TILE_EMPTY=0, TILE_WALL=1, TILE_PILL=2, TILE_PACMAN=3, TILE_GHOST=4
  - MAP_W/MAP_H defaults
  - the state enum typedef
  - the address-packing function {y,x}
- One sub-module: rr_arbiter (NREQ-wide request vector, mask vector and ptr in; one-hot grant and valid out; combinational).

## Test plan
- Single move: req[0] with old (20,20) EMPTY, new (20,19) PACMAN → writes addr {20,20}=0 then {19,20}=3 on consecutive cycles; done[0] in cycle t+3; busy high for 3 cycles.
- Contention: req[0], req[2] and req[4] all raised at the same cycle with ptr=0 → served in order 0, 2, 4; each done 4 cycles apart; no two wren cycles overlap between services.
- Wall collision: old = new = (5,7) for req[1] → WR_OLD cycle has wren=0; addr {7,5} written once with new_tile; done[1] pulses.
- Out of range: new_x=45 → second write suppressed; drop=1 and done pulse together; old write still occurs.
- Reset during WR_NEW → wren 0 next cycle, no done, ptr 0; a fresh req is then served normally.
- With SCHED_VBLANK_GATE_EN: req held while vblank=0 → no wren; vblank rises → WR_OLD one cycle after the sampling edge.
